// File: rtl/noc_input_fifo.sv
// noc_input_fifo: FWFT per-port input buffer with credit return; FIFO_FRAMING_CHECK_EN enables the packet framing checker.
module noc_input_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int PTR_W      = 2,
   parameter int ADDR_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read_en,
   output logic                  credit_out,
   output logic                  empty,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [2:0]            flit_id,
   output logic [ADDR_W-1:0]     dst_addr,
   output logic                  overflow_err,
   output logic                  framing_err
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [PTR_W:0]        count;
   logic                  pop, wr;
   assign empty    = count == '0;
   assign full     = count == (PTR_W+1)'(DEPTH);
   assign pop      = read_en && !empty;
   assign wr       = valid_in && (!full || pop);
   assign data_out = mem[rd_ptr];
   assign flit_id  = data_out[DATA_WIDTH-1 -: 3];
   assign dst_addr = data_out[ADDR_W-1:0];
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= data_in;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         credit_out   <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         rd_ptr       <= rd_ptr + PTR_W'(pop);
         wr_ptr       <= wr_ptr + PTR_W'(wr);
         count        <= count + (PTR_W+1)'(wr) - (PTR_W+1)'(pop);
         credit_out   <= pop;
         overflow_err <= overflow_err | (valid_in && full && !pop);
      end
   end
`ifdef FIFO_FRAMING_CHECK_EN
   typedef enum logic {IDLE, IN_PKT} state_t;
   state_t     state, state_nxt;
   logic [2:0] id_in;
   logic       ok, ferr_set;
   assign id_in = data_in[DATA_WIDTH-1 -: 3];
   assign ok    = state == IDLE ? id_in == 3'b001 : (id_in == 3'b010 || id_in == 3'b100);
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         framing_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         framing_err <= framing_err | ferr_set;
      end
   end
   // Bad flits still land in storage; the checker only flags and resyncs to IDLE.
   always_comb begin
      state_nxt = !wr ? state : (ok && id_in != 3'b100) ? IN_PKT : IDLE;
   end
   always_comb begin
      ferr_set = wr && !ok;
   end
`else
   assign framing_err = 1'b0;
`endif
endmodule

// File: tb/tb_noc_input_fifo.sv
// tb_noc_input_fifo: table-driven plus directed-sequence check of noc_input_fifo.
module tb_noc_input_fifo;
`ifdef FIFO_FRAMING_CHECK_EN
   localparam bit FR = 1'b1;
`else
   localparam bit FR = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b0, valid_in = 1'b0, read_en = 1'b0;
   logic [31:0] data_in = '0;
   logic        credit_out, empty, full, overflow_err, framing_err;
   logic [31:0] data_out;
   logic [2:0]  flit_id;
   logic [3:0]  dst_addr;
   int          errors = 0, checks = 0;
   noc_input_fifo dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .read_en(read_en),
      .credit_out(credit_out), .empty(empty), .full(full), .data_out(data_out),
      .flit_id(flit_id), .dst_addr(dst_addr), .overflow_err(overflow_err), .framing_err(framing_err)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        e_empty, e_full, e_credit, e_ovf, chk;
      logic [31:0] e_data;
   } vec_t;
   vec_t tbl [10];
   logic [31:0] q [$];
   logic [31:0] w;
   bit          popped;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step(input logic v, input logic [31:0] d, input logic r);
      @(negedge clk);
      valid_in = v;
      data_in  = d;
      read_en  = r;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset(input logic v, input logic r);
      @(negedge clk);
      rst      = 1'b1;
      valid_in = v;
      data_in  = 32'h2000_0003;
      read_en  = r;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_credit", 32'(credit_out), 32'd0);
      chk("rst_ovf", 32'(overflow_err), 32'd0);
      chk("rst_ferr", 32'(framing_err), 32'd0);
   endtask
   initial begin
      tbl[0] = '{1, 32'h2000_0009, 0, 0, 0, 0, 0, 1, 32'h2000_0009};
      tbl[1] = '{1, 32'h4000_0001, 0, 0, 0, 0, 0, 1, 32'h2000_0009};
      tbl[2] = '{1, 32'h8000_0002, 0, 0, 0, 0, 0, 1, 32'h2000_0009};
      tbl[3] = '{1, 32'h2000_0005, 0, 0, 1, 0, 0, 1, 32'h2000_0009};
      tbl[4] = '{1, 32'h4000_0077, 0, 0, 1, 0, 1, 1, 32'h2000_0009};
      tbl[5] = '{0, 32'h0,         1, 0, 0, 1, 1, 1, 32'h4000_0001};
      tbl[6] = '{0, 32'h0,         1, 0, 0, 1, 1, 1, 32'h8000_0002};
      tbl[7] = '{0, 32'h0,         1, 0, 0, 1, 1, 1, 32'h2000_0005};
      tbl[8] = '{0, 32'h0,         1, 1, 0, 1, 1, 0, 32'h0};
      tbl[9] = '{0, 32'h0,         0, 1, 0, 0, 1, 0, 32'h0};
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r);
         chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
         chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_full));
         chk($sformatf("v%0d_credit", i), 32'(credit_out), 32'(tbl[i].e_credit));
         chk($sformatf("v%0d_ovf", i), 32'(overflow_err), 32'(tbl[i].e_ovf));
         chk($sformatf("v%0d_ferr", i), 32'(framing_err), 32'd0);
         if (tbl[i].chk) begin
            chk($sformatf("v%0d_data", i), data_out, tbl[i].e_data);
            chk($sformatf("v%0d_id", i), 32'(flit_id), 32'(tbl[i].e_data[31:29]));
            chk($sformatf("v%0d_dst", i), 32'(dst_addr), 32'(tbl[i].e_data[3:0]));
         end
      end
      // full FIFO: simultaneous write and pop is accepted
      do_reset(1'b0, 1'b0);
      step(1, 32'h2000_0001, 0);
      step(1, 32'h4000_0002, 0);
      step(1, 32'h4000_0003, 0);
      step(1, 32'h4000_0004, 0);
      chk("t3_full_before", 32'(full), 32'd1);
      step(1, 32'h8000_0005, 1);
      chk("t3_full_after", 32'(full), 32'd1);
      chk("t3_ovf", 32'(overflow_err), 32'd0);
      chk("t3_credit", 32'(credit_out), 32'd1);
      chk("t3_head", data_out, 32'h4000_0002);
      step(0, 32'h0, 0);
      chk("t3_credit_once", 32'(credit_out), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, 32'h0, 1);
         chk($sformatf("t3_drain%0d_credit", i), 32'(credit_out), 32'd1);
      end
      chk("t3_drain_empty", 32'(empty), 32'd1);
      chk("t3_ferr", 32'(framing_err), 32'd0);
      // streaming write/pop with pointer wrap
      do_reset(1'b0, 1'b0);
      q.delete();
      for (int i = 0; i < 11; i++) begin
         w = i == 0 ? 32'h2000_0000 : i == 9 ? 32'h8000_0000 : 32'h4000_0000;
         w[15:0] = 16'(i * 37 + 5);
         popped = q.size() > 0;
         if (i < 10) step(1, w, popped); else step(0, 32'h0, popped);
         if (popped) void'(q.pop_front());
         if (i < 10) q.push_back(w);
         chk($sformatf("t4_%0d_credit", i), 32'(credit_out), 32'(popped));
         chk($sformatf("t4_%0d_empty", i), 32'(empty), 32'(q.size() == 0));
         if (q.size() > 0) chk($sformatf("t4_%0d_data", i), data_out, q[0]);
      end
      chk("t4_ferr", 32'(framing_err), 32'd0);
      step(0, 32'h0, 1);
      chk("t4_emptyrd_credit", 32'(credit_out), 32'd0);
      step(0, 32'h0, 1);
      chk("t4_emptyrd_credit2", 32'(credit_out), 32'd0);
      chk("t4_emptyrd_empty", 32'(empty), 32'd1);
      step(1, 32'h2000_00AB, 0);
      chk("t4_after_empty", 32'(empty), 32'd0);
      chk("t4_after_data", data_out, 32'h2000_00AB);
      step(0, 32'h0, 1);
      chk("t4_after_pop_empty", 32'(empty), 32'd1);
      chk("t4_after_pop_credit", 32'(credit_out), 32'd1);
      // framing: header followed by header
      do_reset(1'b0, 1'b0);
      step(1, 32'h2000_0001, 0);
      chk("t5_hdr1_ferr", 32'(framing_err), 32'd0);
      step(1, 32'h2000_0002, 0);
      chk("t5_hdr2_ferr", 32'(framing_err), 32'(FR));
      chk("t5_hdr2_stored", data_out, 32'h2000_0001);
      // framing: body while idle
      do_reset(1'b0, 1'b0);
      step(1, 32'h4000_0001, 0);
      chk("t5_body_ferr", 32'(framing_err), 32'(FR));
      // rejected writes do not advance the checker
      do_reset(1'b0, 1'b0);
      step(1, 32'h2000_0001, 0);
      step(1, 32'h4000_0002, 0);
      step(1, 32'h4000_0003, 0);
      step(1, 32'h4000_0004, 0);
      step(1, 32'h2000_0009, 0);
      chk("t5_rej_ovf", 32'(overflow_err), 32'd1);
      chk("t5_rej_ferr", 32'(framing_err), 32'd0);
      step(1, 32'h8000_0005, 1);
      chk("t5_tail_ferr", 32'(framing_err), 32'd0);
      // reset mid-packet with errors pending and two flits stored
      do_reset(1'b0, 1'b0);
      step(1, 32'h2000_0001, 0);
      step(1, 32'h2000_0002, 0);
      step(1, 32'h4000_0003, 0);
      step(1, 32'h4000_0004, 0);
      step(1, 32'h4000_0005, 0);
      chk("t6_pre_ovf", 32'(overflow_err), 32'd1);
      chk("t6_pre_ferr", 32'(framing_err), 32'(FR));
      step(0, 32'h0, 1);
      step(0, 32'h0, 1);
      chk("t6_two_left", data_out, 32'h4000_0003);
      do_reset(1'b1, 1'b1);
      step(1, 32'h2000_0006, 0);
      chk("t6_hdr_ferr", 32'(framing_err), 32'd0);
      chk("t6_hdr_data", data_out, 32'h2000_0006);
      chk("t6_hdr_dst", 32'(dst_addr), 32'd6);
      chk("t6_hdr_credit", 32'(credit_out), 32'd0);
      step(1, 32'h8000_0007, 0);
      chk("t6_tail_ferr", 32'(framing_err), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/noc_input_fifo.md
Name: noc_input_fifo

Overview:
Per-port input buffer of the NoC router; sits directly upstream of the LBDR routing stage.
Stores incoming flits from the link in a first-word-fall-through FIFO and returns one credit per flit consumed.
Exposes the head flit's type, destination address and payload, plus an empty flag, to LBDR and the switch allocator.

Parameters:
DATA_WIDTH, 32, flit width in bits; [31:29] = flit_id, one-hot: 001 header, 010 body, 100 tail.
DEPTH, 4, FIFO entries; must be a power of two, 2..16.
PTR_W, 2, log2(DEPTH).
ADDR_W, 4, destination address width; header flit carries dst at [ADDR_W-1:0].

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
valid_in  input  1  upstream link has a flit on data_in this cycle.
data_in  input  DATA_WIDTH  incoming flit.
read_en  input  1  allocator pops the head flit this cycle.
credit_out  output  1  one-cycle pulse per flit popped; returned to the upstream router.
empty  output  1  FIFO holds no flits.
full  output  1  FIFO holds DEPTH flits.
data_out  output  DATA_WIDTH  head flit (FWFT).
flit_id  output  3  data_out[31:29].
dst_addr  output  ADDR_W  data_out[ADDR_W-1:0]; meaningful only when flit_id = 001.
overflow_err  output  1  sticky: write attempted while full with no pop.
framing_err  output  1  sticky: packet framing violation (optional feature).

Behaviour:
- Reset (rst=1 at posedge): rd_ptr, wr_ptr and count go to 0; empty=1, full=0, credit_out=0, overflow_err=0, framing_err=0; framing FSM returns to IDLE. Storage contents are not reset. Reset overrides all other inputs in the same cycle; an in-flight packet is discarded.
- count is PTR_W+1 bits. empty = (count==0), full = (count==DEPTH); both derive from registered count.
- Write accepted when valid_in && (!full || pop). The flit is stored at wr_ptr; wr_ptr increments modulo DEPTH, wrapping naturally at PTR_W bits.
- pop = read_en && !empty. rd_ptr increments modulo DEPTH. read_en while empty is ignored: no pointer change, no credit.
- Simultaneous accepted write and pop: count is unchanged. This holds when full, because the pop frees the slot in the same cycle. When empty, a same-cycle write is not visible until the next cycle.
- Rejected write (valid_in && full && !pop): the flit is dropped and overflow_err is set. It clears only on rst.
- data_out = mem[rd_ptr], combinational from storage. A written flit appears on data_out and empty deasserts 1 cycle after the write edge.
- credit_out is registered: asserted for exactly one cycle, the cycle after each pop. Back-to-back pops give back-to-back credit pulses.
- flit_id and dst_addr are pure slices of data_out. No extra latency, so LBDR sees the head flit's fields in the same cycle empty=0.

Optional Feature:
Macro FIFO_FRAMING_CHECK_EN.
- Defined: a 2-state write-side FSM (IDLE, IN_PKT) checks each accepted flit.
  - IDLE + header → IN_PKT.
  - IN_PKT + body → stay.
  - IN_PKT + tail → IDLE.
  - Any other flit_id (including non-one-hot) sets framing_err (sticky) and the FSM goes to IDLE. The flit is still stored.
  - Rejected writes do not advance the FSM.
- Undefined: no FSM; framing_err tied to 0.

Test Plan:
1. Reset, then write header 0x2000_0009, body 0x4000_0001, tail 0x8000_0002 on consecutive cycles, no reads → empty=0 one cycle after first write; flit_id=001, dst_addr=4'h9; count=3, full=0.
2. Write 4 flits with read_en=0 → full=1. Assert valid_in with read_en=0 → flit dropped, overflow_err=1. Then 4 pops → data_out order matches writes, 4 credit pulses each one cycle after its pop, empty=1.
3. FIFO full, valid_in=1 and read_en=1 same cycle → write accepted, count stays 4, overflow_err stays 0, one credit pulse.
4. Write/pop continuously for 10 flits → pointers wrap past 3→0 and data integrity holds; read_en on empty FIFO → no credit, pointers unchanged.
5. FIFO_FRAMING_CHECK_EN defined: header, header → framing_err=1 on the second. Separately, body with FSM in IDLE → framing_err=1. With the macro undefined, the same stimulus gives framing_err=0.
6. rst asserted mid-packet with 2 flits stored → next cycle empty=1, credit_out=0, errors cleared, FSM IDLE; a new header is accepted without framing_err.
